mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data bus width; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter MAX_WAIT, default 16, bus cycles without ack before timeout; minimum 1.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  MEM-stage op present; in_ready  out  1  block can accept.
REQ-007 mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE.
REQ-008 addr  in  ADDR_W  effective byte address; wdata  in  32  store source register.
REQ-009 flush  in  1  discard the in-flight op (exception or ERET upstream).
REQ-010 out_valid  out  1  one-cycle completion pulse; rdata  out  32  extended load result.
REQ-011 exc_valid  out  1  with out_valid, op faulted; exc_code  out  5  4 AdEL, 5 AdES, 7 DBE; bad_vaddr  out  ADDR_W.
REQ-012 bus_req, bus_we  out  1; bus_addr  out  ADDR_W; bus_be  out  DATA_W/8; bus_wdata  out  DATA_W.
REQ-013 bus_ack  in  1  one-cycle transfer completion; bus_rdata  in  DATA_W  valid with bus_ack.

Function
REQ-014 States IDLE, REQ, RESP; in_ready = 1 only in IDLE.
REQ-015 Accept occurs when in_valid and in_ready on a rising edge; op, addr, wdata are registered at accept.
REQ-016 From IDLE: NONE -> RESP; misaligned -> RESP with fault; aligned load/store -> REQ.
REQ-017 Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; loads give AdEL, stores give AdES; no bus request is issued.
REQ-018 In REQ, bus_req = 1 and bus_addr, bus_we, bus_be, bus_wdata are held stable until the bus_ack cycle inclusive.
REQ-019 bus_addr = addr with its low log2(DATA_W/8) bits cleared; lane = those low bits.
REQ-020 bus_be = 1<<lane for byte, 3<<lane for half, 4'hF<<lane for word ops; bus_be = 0 for loads is forbidden; loads drive the same mask.
REQ-021 bus_wdata = store byte, half or word replicated across all DATA_W/8 byte lanes.
REQ-022 bus_ack in REQ -> RESP; rdata = bus_rdata byte/half/word at bit lane*8; LB/LH sign-extend, LBU/LHU zero-extend to 32; LW is unmodified.
REQ-023 A wait counter is cleared on entry to REQ and increments each REQ cycle without ack; at MAX_WAIT -> RESP with exc DBE, bus_req deasserted.
REQ-024 RESP lasts exactly one cycle with out_valid = 1, then returns to IDLE; new accept is possible the following cycle.
REQ-025 Latency: NONE or misaligned op gives out_valid 1 cycle after accept; bus op gives out_valid 1 cycle after the bus_ack cycle.
REQ-026 bad_vaddr = registered addr when exc_valid; otherwise 0; rdata = 0 for stores, NONE and faults.
REQ-027 Flush in IDLE: no effect. Flush in RESP: out_valid is suppressed that cycle.
REQ-028 Flush in REQ: the bus transaction runs to ack or timeout (no abort); the completion is dropped with no out_valid; the block then returns to IDLE.
REQ-029 Flush and accept in the same cycle: flush wins and the op is not accepted.
REQ-030 bus_ack outside REQ is ignored.

Reset
REQ-031 rst forces IDLE and wait counter 0 in the same cycle, regardless of state; mid-REQ reset abandons the transaction.
REQ-032 Reset values: in_ready 1; out_valid, exc_valid, bus_req, bus_we 0; exc_code, bad_vaddr, rdata, bus_addr, bus_be, bus_wdata all 0.

Verification
REQ-033 DATA_W=32, LB addr 0x1003, ack 2 cycles later with bus_rdata 0x80FF_0000 -> bus_addr 0x1000, be 4'b1000, rdata 0xFFFF_FF80, out_valid 1 cycle after ack.
REQ-034 SH addr 0x2002, wdata 0x1234_ABCD -> bus_we 1, be 4'b1100, bus_wdata 0xABCD_ABCD, out_valid with exc_valid 0.
REQ-035 LW addr 0x3001 -> no bus_req, out_valid+exc_valid next cycle, exc_code 4, bad_vaddr 0x3001; SW same address gives exc_code 5.
REQ-036 LHU addr 0x4006 with MAX_WAIT=4 and no ack -> bus_req high 4 cycles, then exc_code 7, bad_vaddr 0x4006.
REQ-037 DATA_W=64, LBU addr 0x5005, bus_rdata byte5=0x9C -> be 8'b0010_0000, rdata 0x0000_009C.
REQ-038 Flush during REQ, then ack -> no out_valid and in_ready high the cycle after ack; rst asserted mid-REQ -> IDLE next cycle with all outputs at reset values.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: one bus transfer per aligned op, with lane steering and load extension.
// IDLE/REQ/RESP FSM; bus timeout raises DBE, flush drops the completion.
module mem_access_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          mem_op,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         wdata,
  input  logic                flush,
  output logic                out_valid,
  output logic [31:0]         rdata,
  output logic                exc_valid,
  output logic [4:0]          exc_code,
  output logic [ADDR_W-1:0]   bad_vaddr,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int CNT_W  = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(MAX_WAIT - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BE_W - 1);

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;

  typedef struct packed {
    logic  ld;
    logic  st;
    logic  sgn;
    size_t sz;
  } op_info_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_t;

  function automatic op_info_t decode_op(input logic [3:0] op);
    op_info_t d;
    d = '{ld: 1'b0, st: 1'b0, sgn: 1'b0, sz: SZ_B};
    case (op)
      4'd1:    d = '{ld: 1'b1, st: 1'b0, sgn: 1'b1, sz: SZ_B};
      4'd2:    d = '{ld: 1'b1, st: 1'b0, sgn: 1'b0, sz: SZ_B};
      4'd3:    d = '{ld: 1'b1, st: 1'b0, sgn: 1'b1, sz: SZ_H};
      4'd4:    d = '{ld: 1'b1, st: 1'b0, sgn: 1'b0, sz: SZ_H};
      4'd5:    d = '{ld: 1'b1, st: 1'b0, sgn: 1'b0, sz: SZ_W};
      4'd6:    d = '{ld: 1'b0, st: 1'b1, sgn: 1'b0, sz: SZ_B};
      4'd7:    d = '{ld: 1'b0, st: 1'b1, sgn: 1'b0, sz: SZ_H};
      4'd8:    d = '{ld: 1'b0, st: 1'b1, sgn: 1'b0, sz: SZ_W};
      default: d = '{ld: 1'b0, st: 1'b0, sgn: 1'b0, sz: SZ_B};
    endcase
    return d;
  endfunction

  function automatic logic misaligned(input op_info_t d, input logic [1:0] a);
    return (d.ld | d.st) &
           (((d.sz == SZ_H) & a[0]) | ((d.sz == SZ_W) & (a != 2'b00)));
  endfunction

  state_t            r_state;
  state_t            w_next;
  op_info_t          r_info;
  op_info_t          w_in_info;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_exc;
  logic [4:0]        r_exc_code;
  logic              r_drop;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_in_misal;
  logic              w_timeout;
  logic [LANE_W-1:0] w_lane;
  logic [31:0]       w_lane_dat;
  logic [31:0]       w_ld_ext;
  logic [BE_W-1:0]   w_mask;

  assign w_in_info  = decode_op(mem_op);
  assign w_in_misal = misaligned(w_in_info, addr[1:0]);
  // Flush wins over a same-cycle accept.
  assign w_accept   = in_valid & (r_state == S_IDLE) & ~flush;
  assign w_timeout  = ~bus_ack & (r_cnt == CNT_LAST);
  assign w_lane     = r_addr[LANE_W-1:0];
  assign w_lane_dat = 32'(bus_rdata >> {w_lane, 3'b000});

  always_comb begin
    w_ld_ext = '0;
    if (r_info.ld) begin
      unique case (r_info.sz)
        SZ_B:    w_ld_ext = {{24{r_info.sgn & w_lane_dat[7]}}, w_lane_dat[7:0]};
        SZ_H:    w_ld_ext = {{16{r_info.sgn & w_lane_dat[15]}}, w_lane_dat[15:0]};
        default: w_ld_ext = w_lane_dat;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = ((w_in_info.ld | w_in_info.st) & ~w_in_misal) ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        // A flushed op still finishes its bus transfer but skips RESP.
        if (bus_ack | w_timeout) begin
          w_next = (r_drop | flush) ? S_IDLE : S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_info     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_exc      <= 1'b0;
      r_exc_code <= '0;
      r_drop     <= 1'b0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      r_info     <= w_in_info;
      r_addr     <= addr;
      r_wdata    <= wdata;
      r_rdata    <= '0;
      r_exc      <= w_in_misal;
      r_exc_code <= w_in_info.st ? EXC_ADES : EXC_ADEL;
      r_drop     <= 1'b0;
      r_cnt      <= '0;
    end else if (r_state == S_REQ) begin
      if (flush) begin
        r_drop <= 1'b1;
      end
      if (bus_ack) begin
        r_rdata <= w_ld_ext;
      end else if (w_timeout) begin
        r_exc      <= 1'b1;
        r_exc_code <= EXC_DBE;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    unique case (r_info.sz)
      SZ_B:    w_mask = BE_W'(4'h1);
      SZ_H:    w_mask = BE_W'(4'h3);
      default: w_mask = BE_W'(4'hF);
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = '0;
    bus_wdata = '0;
    out_valid = 1'b0;
    exc_valid = 1'b0;
    exc_code  = '0;
    bad_vaddr = '0;
    rdata     = '0;
    if (r_state == S_REQ) begin
      bus_req  = 1'b1;
      bus_we   = r_info.st;
      bus_addr = r_addr & ALIGN_MASK;
      bus_be   = w_mask << w_lane;
      unique case (r_info.sz)
        SZ_B:    bus_wdata = {BE_W{r_wdata[7:0]}};
        SZ_H:    bus_wdata = {(BE_W/2){r_wdata[15:0]}};
        default: bus_wdata = {(BE_W/4){r_wdata}};
      endcase
    end
    if ((r_state == S_RESP) && !r_drop && !flush) begin
      out_valid = 1'b1;
      exc_valid = r_exc;
      exc_code  = r_exc ? r_exc_code : 5'd0;
      bad_vaddr = r_exc ? r_addr : '0;
      rdata     = r_exc ? 32'd0 : r_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a 32-bit instance (MAX_WAIT=4) and a 64-bit instance,
// each with an expected-completion queue checked by its own monitor.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_exc_valid;
  logic        a_bus_req, a_bus_we, a_bus_ack;
  logic [3:0]  a_mem_op, a_bus_be;
  logic [31:0] a_addr, a_wdata, a_rdata, a_bad_vaddr, a_bus_addr, a_bus_wdata, a_bus_rdata;
  logic [4:0]  a_exc_code;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_exc_valid;
  logic        b_bus_req, b_bus_we, b_bus_ack;
  logic [3:0]  b_mem_op;
  logic [7:0]  b_bus_be;
  logic [31:0] b_addr, b_wdata, b_rdata, b_bad_vaddr, b_bus_addr;
  logic [63:0] b_bus_wdata, b_bus_rdata;
  logic [4:0]  b_exc_code;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .mem_op(a_mem_op), .addr(a_addr), .wdata(a_wdata), .flush(a_flush),
    .out_valid(a_out_valid), .rdata(a_rdata), .exc_valid(a_exc_valid),
    .exc_code(a_exc_code), .bad_vaddr(a_bad_vaddr), .bus_req(a_bus_req),
    .bus_we(a_bus_we), .bus_addr(a_bus_addr), .bus_be(a_bus_be),
    .bus_wdata(a_bus_wdata), .bus_ack(a_bus_ack), .bus_rdata(a_bus_rdata)
  );

  mem_access_ctrl #(.DATA_W(64), .ADDR_W(32), .MAX_WAIT(16)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mem_op(b_mem_op), .addr(b_addr), .wdata(b_wdata), .flush(b_flush),
    .out_valid(b_out_valid), .rdata(b_rdata), .exc_valid(b_exc_valid),
    .exc_code(b_exc_code), .bad_vaddr(b_bad_vaddr), .bus_req(b_bus_req),
    .bus_we(b_bus_we), .bus_addr(b_bus_addr), .bus_be(b_bus_be),
    .bus_wdata(b_bus_wdata), .bus_ack(b_bus_ack), .bus_rdata(b_bus_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] bad;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_a(input logic [31:0] rd, input logic exc, input logic [4:0] code, input logic [31:0] bad);
    exp_t e;
    e.rdata = rd; e.exc = exc; e.code = code; e.bad = bad;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] rd, input logic exc, input logic [4:0] code, input logic [31:0] bad);
    exp_t e;
    e.rdata = rd; e.exc = exc; e.code = code; e.bad = bad;
    qb.push_back(e);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_out_valid === 1'b1) begin
      if (qa.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected: out_valid=1 with no completion expected");
      end else begin
        e = qa.pop_front();
        chk("a_rdata", a_rdata, e.rdata);
        chk("a_exc_valid", a_exc_valid, e.exc);
        chk("a_exc_code", a_exc_code, e.code);
        chk("a_bad_vaddr", a_bad_vaddr, e.bad);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_out_valid === 1'b1) begin
      if (qb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected: out_valid=1 with no completion expected");
      end else begin
        e = qb.pop_front();
        chk("b_rdata", b_rdata, e.rdata);
        chk("b_exc_valid", b_exc_valid, e.exc);
        chk("b_exc_code", b_exc_code, e.code);
        chk("b_bad_vaddr", b_bad_vaddr, e.bad);
      end
    end
  end

  // Bus op on the 32-bit instance; ack arrives after 'waits' plain REQ cycles.
  task automatic a_bus_op(input string nm, input logic [3:0] op, input logic [31:0] ad,
                          input logic [31:0] wd, input int waits, input logic [31:0] brd,
                          input logic [31:0] e_addr, input logic [3:0] e_be, input logic e_we,
                          input logic [31:0] e_wd, input logic [31:0] e_rd);
    a_in_valid = 1'b1; a_mem_op = op; a_addr = ad; a_wdata = wd;
    push_a(e_rd, 1'b0, 5'd0, 32'd0);
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < waits; i++) begin
      sample();
      chk({nm, "_req_wait"}, a_bus_req, 1'b1);
      chk({nm, "_addr_wait"}, a_bus_addr, e_addr);
      step();
    end
    a_bus_ack = 1'b1; a_bus_rdata = brd;
    sample();
    chk({nm, "_req"}, a_bus_req, 1'b1);
    chk({nm, "_addr"}, a_bus_addr, e_addr);
    chk({nm, "_be"}, a_bus_be, e_be);
    chk({nm, "_we"}, a_bus_we, e_we);
    if (e_we) chk({nm, "_wdata"}, a_bus_wdata, e_wd);
    step();
    a_bus_ack = 1'b0; a_bus_rdata = '0;
    sample();
    chk({nm, "_out_valid"}, a_out_valid, 1'b1);
    chk({nm, "_req_off"}, a_bus_req, 1'b0);
    step();
  endtask

  task automatic b_bus_op(input string nm, input logic [3:0] op, input logic [31:0] ad,
                          input logic [31:0] wd, input logic [63:0] brd,
                          input logic [31:0] e_addr, input logic [7:0] e_be, input logic e_we,
                          input logic [63:0] e_wd, input logic [31:0] e_rd);
    b_in_valid = 1'b1; b_mem_op = op; b_addr = ad; b_wdata = wd;
    push_b(e_rd, 1'b0, 5'd0, 32'd0);
    step();
    b_in_valid = 1'b0;
    b_bus_ack = 1'b1; b_bus_rdata = brd;
    sample();
    chk({nm, "_addr"}, b_bus_addr, e_addr);
    chk({nm, "_be"}, b_bus_be, e_be);
    chk({nm, "_we"}, b_bus_we, e_we);
    if (e_we) chk({nm, "_wdata"}, b_bus_wdata, e_wd);
    step();
    b_bus_ack = 1'b0; b_bus_rdata = '0;
    sample();
    chk({nm, "_out_valid"}, b_out_valid, 1'b1);
    step();
  endtask

  // NONE or misaligned op: no bus request, completion in the cycle after accept.
  task automatic a_fast(input string nm, input logic [3:0] op, input logic [31:0] ad,
                        input logic e_exc, input logic [4:0] e_code, input logic [31:0] e_bad);
    a_in_valid = 1'b1; a_mem_op = op; a_addr = ad; a_wdata = 32'hFFFF_FFFF;
    push_a(32'd0, e_exc, e_code, e_bad);
    step();
    a_in_valid = 1'b0;
    sample();
    chk({nm, "_no_req"}, a_bus_req, 1'b0);
    chk({nm, "_out_valid"}, a_out_valid, 1'b1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_req;
    logic done;
    rst = 1'b1;
    a_in_valid = 0; a_mem_op = 0; a_addr = 0; a_wdata = 0; a_flush = 0; a_bus_ack = 0; a_bus_rdata = 0;
    b_in_valid = 0; b_mem_op = 0; b_addr = 0; b_wdata = 0; b_flush = 0; b_bus_ack = 0; b_bus_rdata = 0;
    step(); step();
    sample();
    chk("rst_in_ready", a_in_ready, 1'b1);
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_exc_valid", a_exc_valid, 1'b0);
    chk("rst_bus_req", a_bus_req, 1'b0);
    chk("rst_bus_be", a_bus_be, 4'h0);
    chk("rst_bus_addr", a_bus_addr, 32'h0);
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_b_in_ready", b_in_ready, 1'b1);
    step();
    rst = 1'b0;

    a_bus_op("lb",   4'd1, 32'h1003, 32'h0,         1, 32'h80FF_0000, 32'h1000, 4'b1000, 1'b0, 32'h0,         32'hFFFF_FF80);
    a_bus_op("sh",   4'd7, 32'h2002, 32'h1234_ABCD, 0, 32'hFFFF_FFFF, 32'h2000, 4'b1100, 1'b1, 32'hABCD_ABCD, 32'h0);
    a_bus_op("lh",   4'd3, 32'h8002, 32'h0,         0, 32'h8001_1234, 32'h8000, 4'b1100, 1'b0, 32'h0,         32'hFFFF_8001);
    a_bus_op("lhu",  4'd4, 32'h8002, 32'h0,         2, 32'h8001_1234, 32'h8000, 4'b1100, 1'b0, 32'h0,         32'h0000_8001);
    a_bus_op("lw",   4'd5, 32'h9000, 32'h0,         0, 32'hDEAD_BEEF, 32'h9000, 4'b1111, 1'b0, 32'h0,         32'hDEAD_BEEF);
    a_bus_op("lbu",  4'd2, 32'h1001, 32'h0,         0, 32'h1234_F156, 32'h1000, 4'b0010, 1'b0, 32'h0,         32'h0000_00F1);
    a_bus_op("lbpos",4'd1, 32'h1000, 32'h0,         0, 32'h1234_F156, 32'h1000, 4'b0001, 1'b0, 32'h0,         32'h0000_0056);
    a_bus_op("sb",   4'd6, 32'h1101, 32'hFFFF_FFA5, 0, 32'h0,         32'h1100, 4'b0010, 1'b1, 32'hA5A5_A5A5, 32'h0);
    a_bus_op("sw",   4'd8, 32'h1204, 32'hCAFE_F00D, 1, 32'h0,         32'h1204, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h0);

    a_fast("lw_mis",  4'd5,  32'h3001, 1'b1, 5'd4, 32'h3001);
    a_fast("sw_mis",  4'd8,  32'h3001, 1'b1, 5'd5, 32'h3001);
    a_fast("lh_mis",  4'd3,  32'h3003, 1'b1, 5'd4, 32'h3003);
    a_fast("sh_mis",  4'd7,  32'h3005, 1'b1, 5'd5, 32'h3005);
    a_fast("none",    4'd0,  32'h3001, 1'b0, 5'd0, 32'h0);
    a_fast("op12",    4'd12, 32'h0010, 1'b0, 5'd0, 32'h0);

    // Bus timeout: MAX_WAIT=4 cycles of bus_req, then DBE.
    a_in_valid = 1'b1; a_mem_op = 4'd4; a_addr = 32'h4006;
    push_a(32'd0, 1'b1, 5'd7, 32'h4006);
    step();
    a_in_valid = 1'b0;
    n_req = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      sample();
      if (a_out_valid === 1'b1) begin
        done = 1'b1;
        chk("to_req_off", a_bus_req, 1'b0);
      end else if (a_bus_req === 1'b1) begin
        n_req++;
      end
      step();
    end
    chk("to_done", done, 1'b1);
    chk("to_req_cycles", n_req, 4);

    // Flush during REQ: transfer completes, completion dropped, IDLE right after ack.
    a_in_valid = 1'b1; a_mem_op = 4'd5; a_addr = 32'h6000;
    step();
    a_in_valid = 1'b0; a_flush = 1'b1;
    sample();
    chk("flreq_out_valid", a_out_valid, 1'b0);
    step();
    a_flush = 1'b0; a_bus_ack = 1'b1; a_bus_rdata = 32'h1111_2222;
    sample();
    chk("flreq_still_req", a_bus_req, 1'b1);
    step();
    a_bus_ack = 1'b0; a_bus_rdata = '0;
    sample();
    chk("flreq_in_ready", a_in_ready, 1'b1);
    chk("flreq_no_out", a_out_valid, 1'b0);
    step();

    // Flush during RESP suppresses out_valid.
    a_in_valid = 1'b1; a_mem_op = 4'd0; a_addr = 32'h0;
    step();
    a_in_valid = 1'b0; a_flush = 1'b1;
    sample();
    chk("flresp_out_valid", a_out_valid, 1'b0);
    step();
    a_flush = 1'b0;
    sample();
    chk("flresp_idle", a_in_ready, 1'b1);
    step();

    // Flush with in_valid in IDLE: op not accepted.
    a_in_valid = 1'b1; a_mem_op = 4'd5; a_addr = 32'h7000; a_flush = 1'b1;
    step();
    a_in_valid = 1'b0; a_flush = 1'b0;
    sample();
    chk("flacc_no_req", a_bus_req, 1'b0);
    chk("flacc_in_ready", a_in_ready, 1'b1);
    step();

    // Stray ack in IDLE is ignored.
    a_bus_ack = 1'b1; a_bus_rdata = 32'h5555_5555;
    step();
    a_bus_ack = 1'b0; a_bus_rdata = '0;
    sample();
    chk("stray_ack_out", a_out_valid, 1'b0);
    chk("stray_ack_ready", a_in_ready, 1'b1);
    step();

    // Reset mid-REQ abandons the transfer.
    a_in_valid = 1'b1; a_mem_op = 4'd1; a_addr = 32'h7001;
    step();
    a_in_valid = 1'b0;
    sample();
    chk("rstreq_req", a_bus_req, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    chk("rstreq_in_ready", a_in_ready, 1'b1);
    chk("rstreq_bus_req", a_bus_req, 1'b0);
    chk("rstreq_bus_addr", a_bus_addr, 32'h0);
    chk("rstreq_bus_be", a_bus_be, 4'h0);
    chk("rstreq_bus_wdata", a_bus_wdata, 32'h0);
    chk("rstreq_out_valid", a_out_valid, 1'b0);
    chk("rstreq_rdata", a_rdata, 32'h0);
    step();
    a_bus_op("post_rst", 4'd1, 32'h1002, 32'h0, 0, 32'h007F_0000, 32'h1000, 4'b0100, 1'b0, 32'h0, 32'h0000_007F);

    b_bus_op("lbu64", 4'd2, 32'h5005, 32'h0,         64'hA1B2_9CD4_E5F6_0718, 32'h5000, 8'b0010_0000, 1'b0, 64'h0, 32'h0000_009C);
    b_bus_op("sw64",  4'd8, 32'h5004, 32'h1122_3344, 64'h0, 32'h5000, 8'hF0, 1'b1, 64'h1122_3344_1122_3344, 32'h0);
    b_bus_op("lh64",  4'd3, 32'h500A, 32'h0,         64'hA1B2_9CD4_E5F6_0718, 32'h5008, 8'h0C, 1'b0, 64'h0, 32'hFFFF_E5F6);
    b_bus_op("lw64",  4'd5, 32'h500C, 32'h0,         64'hA1B2_9CD4_E5F6_0718, 32'h5008, 8'hF0, 1'b0, 64'h0, 32'hA1B2_9CD4);
    b_bus_op("sb64",  4'd6, 32'h5003, 32'h0000_0077, 64'h0, 32'h5000, 8'h08, 1'b1, 64'h7777_7777_7777_7777, 32'h0);

    b_in_valid = 1'b1; b_mem_op = 4'd5; b_addr = 32'h5006;
    push_b(32'd0, 1'b1, 5'd4, 32'h5006);
    step();
    b_in_valid = 1'b0;
    sample();
    chk("b_mis_no_req", b_bus_req, 1'b0);
    chk("b_mis_out_valid", b_out_valid, 1'b1);
    step();

    repeat (3) step();
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
